// File: rtl/vproc_mac_pipe_if.sv
// Handshake bundle for the multi-lane MAC pipeline.
// master drives operand beats and out_ready; slave is the pipeline.
interface vproc_mac_pipe_if #(
    parameter int unsigned OP_W  = 16,
    parameter int unsigned LANES = 2,
    parameter int unsigned TAG_W = 4
);
    logic                          in_valid_i;
    logic                          in_ready_o;
    logic [TAG_W-1:0]              in_tag_i;
    logic [LANES*OP_W-1:0]         op1_i;
    logic [LANES*OP_W-1:0]         op2_i;
    logic                          op1_signed_i;
    logic                          op2_signed_i;
    logic [LANES*2*OP_W-1:0]       acc_i;
    logic                          acc_en_i;
    logic                          acc_sub_i;
    logic [LANES-1:0]              lane_en_i;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic [TAG_W-1:0]              out_tag_o;
    logic [LANES*(2*OP_W+2)-1:0]   res_o;

    modport master (
        output in_valid_i, in_tag_i, op1_i, op2_i,
        output op1_signed_i, op2_signed_i,
        output acc_i, acc_en_i, acc_sub_i, lane_en_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o, out_tag_o, res_o
    );

    modport slave (
        input  in_valid_i, in_tag_i, op1_i, op2_i,
        input  op1_signed_i, op2_signed_i,
        input  acc_i, acc_en_i, acc_sub_i, lane_en_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o, out_tag_o, res_o
    );
endinterface

// File: rtl/vproc_mac_pipe.sv
// Multi-lane exact multiply-accumulate pipeline, 1..3 stages,
// valid/ready on both sides with flush.
module vproc_mac_pipe #(
    parameter int unsigned OP_W   = 16,
    parameter int unsigned LANES  = 2,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input logic             clk_i,
    input logic             async_rst_ni,
    input logic             flush_i,
    vproc_mac_pipe_if.slave bus
);
    localparam int unsigned AW    = OP_W + 1;
    localparam int unsigned ACC_W = 2 * OP_W;
    localparam int unsigned RES_W = 2 * OP_W + 2;

    typedef logic [LANES-1:0][AW-1:0]    opv_t;
    typedef logic [LANES-1:0][RES_W-1:0] resv_t;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] inv;
    logic [STAGES-1:0] ld;
    logic              accept;

    // A stage can take a beat if it or any stage after it is empty.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            rdy[s] = bus.out_ready_i;
            for (int j = s; j < STAGES; j++)
                if (!vld_q[j]) rdy[s] = 1'b1;
        end
    end

    assign bus.in_ready_o = !flush_i && rdy[0];
    assign accept         = bus.in_valid_i && bus.in_ready_o;

    always_comb begin
        inv[0] = accept;
        for (int s = 1; s < STAGES; s++)
            inv[s] = vld_q[s-1];
        ld = inv & rdy & {STAGES{!flush_i}};
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            vld_q <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++)
                if (rdy[s]) vld_q[s] <= inv[s];
        end
    end

    opv_t  fa, fb;
    resv_t fc;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            fa[k] = {bus.op1_signed_i & bus.op1_i[k*OP_W+OP_W-1],
                     bus.op1_i[k*OP_W +: OP_W]};
            fb[k] = {bus.op2_signed_i & bus.op2_i[k*OP_W+OP_W-1],
                     bus.op2_i[k*OP_W +: OP_W]};
            fc[k] = bus.acc_en_i
                  ? {{2{bus.acc_i[k*ACC_W+ACC_W-1]}},
                     bus.acc_i[k*ACC_W +: ACC_W]}
                  : '0;
        end
    end

    opv_t             ma, mb;
    resv_t            mc;
    logic             m_sub;
    logic [LANES-1:0] m_en;
    logic [TAG_W-1:0] m_tag;

    if (STAGES == 3) begin : g_op
        opv_t             a_q, b_q;
        resv_t            c_q;
        logic             sub_q;
        logic [LANES-1:0] en_q;
        logic [TAG_W-1:0] tag_q;

        always_ff @(posedge clk_i or negedge async_rst_ni) begin
            if (!async_rst_ni) begin
                a_q   <= '0;
                b_q   <= '0;
                c_q   <= '0;
                sub_q <= 1'b0;
                en_q  <= '0;
                tag_q <= '0;
            end else if (ld[0]) begin
                a_q   <= fa;
                b_q   <= fb;
                c_q   <= fc;
                sub_q <= bus.acc_sub_i;
                en_q  <= bus.lane_en_i;
                tag_q <= bus.in_tag_i;
            end
        end

        assign ma    = a_q;
        assign mb    = b_q;
        assign mc    = c_q;
        assign m_sub = sub_q;
        assign m_en  = en_q;
        assign m_tag = tag_q;
    end else begin : g_no_op
        assign ma    = fa;
        assign mb    = fb;
        assign mc    = fc;
        assign m_sub = bus.acc_sub_i;
        assign m_en  = bus.lane_en_i;
        assign m_tag = bus.in_tag_i;
    end

    // Both factors sign-extended to RES_W so the product is exact.
    resv_t mp;

    always_comb begin
        for (int k = 0; k < LANES; k++)
            mp[k] = $signed({{AW{ma[k][AW-1]}}, ma[k]})
                  * $signed({{AW{mb[k][AW-1]}}, mb[k]});
    end

    resv_t            rp, rc;
    logic             r_sub;
    logic [LANES-1:0] r_en;
    logic [TAG_W-1:0] r_tag;

    if (STAGES >= 2) begin : g_prod
        resv_t            p_q, c_q;
        logic             sub_q;
        logic [LANES-1:0] en_q;
        logic [TAG_W-1:0] tag_q;

        always_ff @(posedge clk_i or negedge async_rst_ni) begin
            if (!async_rst_ni) begin
                p_q   <= '0;
                c_q   <= '0;
                sub_q <= 1'b0;
                en_q  <= '0;
                tag_q <= '0;
            end else if (ld[STAGES-2]) begin
                p_q   <= mp;
                c_q   <= mc;
                sub_q <= m_sub;
                en_q  <= m_en;
                tag_q <= m_tag;
            end
        end

        assign rp    = p_q;
        assign rc    = c_q;
        assign r_sub = sub_q;
        assign r_en  = en_q;
        assign r_tag = tag_q;
    end else begin : g_no_prod
        assign rp    = mp;
        assign rc    = mc;
        assign r_sub = m_sub;
        assign r_en  = m_en;
        assign r_tag = m_tag;
    end

    resv_t rr;

    always_comb begin
        for (int k = 0; k < LANES; k++)
            rr[k] = !r_en[k] ? '0
                  : r_sub    ? rc[k] - rp[k]
                  :            rc[k] + rp[k];
    end

    resv_t            res_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            res_q <= '0;
            tag_q <= '0;
        end else if (ld[STAGES-1]) begin
            res_q <= rr;
            tag_q <= r_tag;
        end
    end

    assign bus.res_o       = res_q;
    assign bus.out_tag_o   = tag_q;
    assign bus.out_valid_o = vld_q[STAGES-1];
endmodule

// File: tb/tb_vproc_mac_pipe.sv
// Scoreboard bench for vproc_mac_pipe: directed vectors plus
// randomized beats against an integer reference model.
module tb_vproc_mac_pipe;
    localparam int OP_W   = 16;
    localparam int LANES  = 2;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;
    localparam int RES_W  = 2 * OP_W + 2;
    localparam int VW     = LANES * RES_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   or_mode = 0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    vproc_mac_pipe_if #(.OP_W(OP_W), .LANES(LANES), .TAG_W(TAG_W)) bus ();

    vproc_mac_pipe #(
        .OP_W(OP_W), .LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)
    ) dut (
        .clk_i(clk),
        .async_rst_ni(rst_n),
        .flush_i(flush),
        .bus(bus)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [VW-1:0]    res;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Integer arithmetic straight from the operation rules.
    function automatic logic [VW-1:0] model(
        input logic [LANES*OP_W-1:0] o1, o2,
        input logic s1, s2,
        input logic [LANES*2*OP_W-1:0] acc,
        input logic ae, sb,
        input logic [LANES-1:0] le);
        logic [VW-1:0] out;
        out = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [OP_W-1:0]   x, y;
            logic [2*OP_W-1:0] z;
            longint a, b, c, r;
            logic [63:0] rv;
            x = o1[k*OP_W +: OP_W];
            y = o2[k*OP_W +: OP_W];
            z = acc[k*2*OP_W +: 2*OP_W];
            a = longint'(x);
            b = longint'(y);
            c = ae ? longint'(z) : 0;
            if (s1 && x[OP_W-1]) a -= (64'sd1 << OP_W);
            if (s2 && y[OP_W-1]) b -= (64'sd1 << OP_W);
            if (ae && z[2*OP_W-1]) c -= (64'sd1 << (2*OP_W));
            r = !le[k] ? 0 : sb ? c - a * b : c + a * b;
            rv = r;
            out[k*RES_W +: RES_W] = rv[RES_W-1:0];
        end
        return out;
    endfunction

    task automatic set_beat(input logic [TAG_W-1:0] tag,
                            input logic [LANES*OP_W-1:0] o1, o2,
                            input logic s1, s2,
                            input logic [LANES*2*OP_W-1:0] acc,
                            input logic ae, sb,
                            input logic [LANES-1:0] le);
        bus.in_tag_i     = tag;
        bus.op1_i        = o1;
        bus.op2_i        = o2;
        bus.op1_signed_i = s1;
        bus.op2_signed_i = s2;
        bus.acc_i        = acc;
        bus.acc_en_i     = ae;
        bus.acc_sub_i    = sb;
        bus.lane_en_i    = le;
    endtask

    task automatic rand_beat(input logic [TAG_W-1:0] tag);
        logic [LANES*OP_W-1:0] o1, o2;
        o1 = ($urandom_range(0, 3) == 0) ? '1 : $urandom;
        o2 = ($urandom_range(0, 3) == 0) ? '1 : $urandom;
        set_beat(tag, o1, o2, 1'($urandom), 1'($urandom),
                 {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                 2'($urandom));
    endtask

    function automatic logic [VW-1:0] cur_model();
        return model(bus.op1_i, bus.op2_i, bus.op1_signed_i,
                     bus.op2_signed_i, bus.acc_i, bus.acc_en_i,
                     bus.acc_sub_i, bus.lane_en_i);
    endfunction

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [VW-1:0] res);
        bit ok = 0;
        int n = 0;
        bus.in_valid_i = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                exp_q.push_back('{bus.in_tag_i, res});
                ok = 1;
            end
            n++;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lat_check(input string nm, input logic [TAG_W-1:0] tag);
        @(negedge clk);
        chk({nm, "_early"}, bus.out_valid_o, 0);
        @(negedge clk);
        chk({nm, "_valid"}, bus.out_valid_o, 1);
        chk({nm, "_tag"}, bus.out_tag_o, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: bus.out_ready_i = 1'b1;
                1: bus.out_ready_i = ($urandom_range(0, 3) != 0);
                default: bus.out_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: pop on every output handshake, check stalled stability.
    initial begin
        bit               held = 0;
        logic [VW-1:0]    hres;
        logic [TAG_W-1:0] htag;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid_o) begin
                if (held) begin
                    chk("stall_res", bus.res_o, hres);
                    chk("stall_tag", bus.out_tag_o, htag);
                end
                if (bus.out_ready_i) begin
                    held = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", bus.out_tag_o, 'x);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_tag", bus.out_tag_o, e.tag);
                        chk("out_res", bus.res_o, e.res);
                    end
                end else begin
                    held = 1;
                    hres = bus.res_o;
                    htag = bus.out_tag_o;
                end
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        bus.in_valid_i = 1'b0;
        set_beat('0, '0, '0, 0, 0, '0, 0, 0, '0);
        #12;
        chk("rst_valid", bus.out_valid_o, 0);
        chk("rst_res", bus.res_o, 0);
        chk("rst_tag", bus.out_tag_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready_o, 1);
        cyc(1);

        // Directed vectors; expected values worked out by hand.
        set_beat(4'd1, 32'h0000_FFFF, 32'h0000_0002, 1, 1,
                 64'h0, 0, 0, 2'b11);
        send({34'h0, 34'h3_FFFF_FFFE});
        lat_check("lat1", 4'd1);
        set_beat(4'd2, 32'hFFFF_0000, 32'hFFFF_0000, 0, 0,
                 64'h7FFF_FFFF_0000_0000, 1, 0, 2'b11);
        send({34'h1_7FFE_0000, 34'h0});
        set_beat(4'd3, 32'hFFFF_0000, 32'hFFFF_0000, 0, 0,
                 64'h7FFF_FFFF_0000_0000, 1, 1, 2'b11);
        send({34'h3_8001_FFFE, 34'h0});
        set_beat(4'd4, 32'h1234_8000, 32'h5678_8000, 1, 0,
                 64'h1111_2222_3333_4444, 0, 0, 2'b01);
        send({34'h0, 34'h3_C000_0000});
        set_beat(4'd5, 32'h0002_0003, 32'h0002_0005, 1, 1,
                 64'hFFFF_FFFF_0000_0064, 1, 1, 2'b11);
        send({34'h3_FFFF_FFFB, 34'h55});
        cyc(5);

        // Back-pressure with a 4-cycle stall mid-stream.
        fork
            begin
                for (int t = 0; t < 6; t++) begin
                    rand_beat(4'(t));
                    send(cur_model());
                end
            end
            begin
                cyc(2);
                or_mode = 2;
                cyc(3);
                @(negedge clk);
                chk("bp_in_ready", bus.in_ready_o, 0);
                chk("bp_out_valid", bus.out_valid_o, 1);
                @(posedge clk);
                #1;
                or_mode = 0;
            end
        join
        cyc(6);

        // Flush with two beats held and a beat offered.
        or_mode = 2;
        cyc(2);
        rand_beat(4'd6);
        send(cur_model());
        rand_beat(4'd7);
        send(cur_model());
        rand_beat(4'd8);
        bus.in_valid_i = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", bus.in_ready_o, 0);
        @(posedge clk);
        exp_q.delete();
        #1;
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid_o, 0);
        @(posedge clk);
        #1;
        or_mode = 0;
        cyc(2);
        rand_beat(4'd9);
        send(cur_model());
        lat_check("lat2", 4'd9);
        cyc(3);

        // Asynchronous reset with beats in flight.
        or_mode = 2;
        cyc(2);
        rand_beat(4'd10);
        bus.acc_en_i = 1'b1;
        bus.lane_en_i = 2'b11;
        bus.acc_i = 64'h1234_5678_1234_5678;
        send(cur_model());
        rand_beat(4'd11);
        send(cur_model());
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid_o, 0);
        chk("arst_res", bus.res_o, 0);
        chk("arst_tag", bus.out_tag_o, 0);
        exp_q.delete();
        cyc(2);
        @(negedge clk);
        rst_n = 1'b1;
        or_mode = 0;
        @(negedge clk);
        chk("arst_in_ready", bus.in_ready_o, 1);
        cyc(6);

        // Randomized regression with back-pressure, gaps and flushes.
        or_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rand_beat(4'(i));
                bus.in_valid_i = 1'($urandom);
                flush = 1'b1;
                @(negedge clk);
                chk("rflush_in_ready", bus.in_ready_o, 0);
                @(posedge clk);
                exp_q.delete();
                #1;
                flush = 1'b0;
                bus.in_valid_i = 1'b0;
            end else begin
                cyc($urandom_range(0, 2));
                rand_beat(4'(i));
                send(cur_model());
            end
        end
        or_mode = 0;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++)
            cyc(1);
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
